// File: rtl/mp64_sram_cpu_port_if.sv
// rtl/mp64_sram_cpu_port_if.sv - CPU request/response bundle for the MP64 SRAM CPU port
interface mp64_sram_cpu_port_if #(
  parameter int ADDR_W_B = 17,
  parameter int DATA_W   = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W_B-1:0]   req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mp64_sram_cpu_port.sv
// rtl/mp64_sram_cpu_port.sv - CPU narrow-port access to tile SRAM with row-collision stall and byte RMW
module mp64_sram_cpu_port #(
  parameter int ADDR_W_B = 17,
  parameter int DATA_W   = 64,
  parameter int ROW_W    = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mp64_sram_cpu_port_if.slave  cpu,
  input  logic                 tile_ce,
  input  logic                 tile_we,
  input  logic [ROW_W-1:0]     tile_row,
  output logic                 b_ce,
  output logic                 b_we,
  output logic [ADDR_W_B-1:0]  b_addr,
  output logic [DATA_W-1:0]    b_wdata,
  input  logic [DATA_W-1:0]    b_rdata,
  output logic [15:0]          stall_cnt
);
  localparam int SEL_W = ADDR_W_B - ROW_W;
  localparam int BE_W  = DATA_W / 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_WAIT   = 3'd1;
  localparam logic [2:0] RMW_MERGE = 3'd2;
  localparam logic [2:0] RMW_WR    = 3'd3;
  localparam logic [2:0] RMW_RERD  = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;

  logic [2:0]          state;
  logic                we_q;
  logic [ADDR_W_B-1:0] addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   merged_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [DATA_W-1:0]   merged;

  logic coll_req;
  logic coll_lat;
  logic accept;
  logic be_full;
  logic be_none;
  logic in_rmw;
  logic stall_evt;

  // A tile write on the wide port to the row we want blocks the narrow port this cycle
  assign coll_req = tile_ce & tile_we & (tile_row == cpu.req_addr[ADDR_W_B-1:SEL_W]);
  assign coll_lat = tile_ce & tile_we & (tile_row == addr_q[ADDR_W_B-1:SEL_W]);

  assign cpu.req_ready = (state == IDLE) & ~coll_req;
  assign accept        = rst_n & cpu.req_valid & cpu.req_ready;
  assign be_full       = &cpu.req_be;
  assign be_none       = ~|cpu.req_be;
  assign cpu.rsp_valid = rst_n & (state == RESP);
  assign cpu.rsp_rdata = rsp_rdata_q;

  assign in_rmw    = (state == RMW_MERGE) | (state == RMW_WR) | (state == RMW_RERD);
  assign stall_evt = ((state == IDLE) & cpu.req_valid & coll_req) | (in_rmw & coll_lat);

  // Byte merge of the latched write data over the word just read back
  always_comb begin
    merged = b_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  // SRAM narrow-port strobes; gated by reset so an abandoned RMW never writes
  always_comb begin
    b_ce    = 1'b0;
    b_we    = 1'b0;
    b_addr  = addr_q;
    b_wdata = merged_q;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (accept) begin
            b_addr  = cpu.req_addr;
            b_wdata = cpu.req_wdata;
            b_ce    = ~cpu.req_we | ~be_none;
            b_we    = cpu.req_we & be_full;
          end
        end
        RMW_WR: begin
          if (!coll_lat) begin
            b_ce = 1'b1;
            b_we = 1'b1;
          end
        end
        RMW_RERD: begin
          if (!coll_lat) b_ce = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Transaction state machine and request/response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      merged_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= cpu.req_we;
            addr_q  <= cpu.req_addr;
            wdata_q <= cpu.req_wdata;
            be_q    <= cpu.req_be;
            if (!cpu.req_we) begin
              state <= RD_WAIT;
            end else if (be_full || be_none) begin
              rsp_rdata_q <= '0;
              state       <= RESP;
            end else begin
              state <= RMW_MERGE;
            end
          end
        end
        RD_WAIT: begin
          rsp_rdata_q <= we_q ? '0 : b_rdata;
          state       <= RESP;
        end
        RMW_MERGE: begin
          merged_q <= merged;
          state    <= coll_lat ? RMW_RERD : RMW_WR;
        end
        RMW_WR: begin
          if (coll_lat) begin
            state <= RMW_RERD;
          end else begin
            rsp_rdata_q <= '0;
            state       <= RESP;
          end
        end
        RMW_RERD: begin
          if (!coll_lat) state <= RMW_MERGE;
        end
        RESP: begin
          if (cpu.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles lost to wide-port row collisions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_mp64_sram_cpu_port.sv
// tb/tb_mp64_sram_cpu_port.sv - self-checking bench for mp64_sram_cpu_port
module tb_mp64_sram_cpu_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tile_ce = 1'b0;
  logic        tile_we = 1'b0;
  logic [13:0] tile_row = '0;
  logic        b_ce;
  logic        b_we;
  logic [16:0] b_addr;
  logic [63:0] b_wdata;
  logic [63:0] b_rdata = '0;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;
  logic [16:0] last_waddr = '0;
  logic [63:0] last_wdata = '0;
  bit          mem_ready = 1'b0;
  logic [63:0] mem [0:1023];
  logic [63:0] ref_mem [int];

  mp64_sram_cpu_port_if #(.ADDR_W_B(17), .DATA_W(64)) cpu_if ();

  mp64_sram_cpu_port #(.ADDR_W_B(17), .DATA_W(64), .ROW_W(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu_if),
    .tile_ce   (tile_ce),
    .tile_we   (tile_we),
    .tile_row  (tile_row),
    .b_ce      (b_ce),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rdata   (b_rdata),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input logic [16:0] a);
    if (a == 17'd9) return 64'h1122334455667788;
    return {15'h0, a, 15'h7FFF, ~a};
  endfunction

  function automatic logic [63:0] tile_word(input logic [16:0] a);
    return {16'hC0DE, 31'h0, a};
  endfunction

  function automatic logic [9:0] tile_addr(input logic [13:0] row, input int k);
    return 10'({row, 3'(k)});
  endfunction

  function automatic logic [63:0] mrg(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [16:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  function automatic int exp_lat(input logic we, input logic [7:0] be);
    if (!we) return 2;
    if (be == 8'hFF || be == 8'h00) return 1;
    return 3;
  endfunction

  // SRAM model: narrow port read data valid the cycle after b_ce, wide port writes whole rows
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 1024; k++) mem[k] <= init_word(17'(k));
      mem_ready <= 1'b1;
    end else begin
      if (b_ce && !b_we) begin
        b_rdata  <= mem[b_addr[9:0]];
        rd_count <= rd_count + 1;
      end
      if (b_ce && b_we) begin
        mem[b_addr[9:0]] <= b_wdata;
        wr_count   <= wr_count + 1;
        last_waddr <= b_addr;
        last_wdata <= b_wdata;
      end
      if (tile_ce && tile_we) begin
        for (int k = 0; k < 8; k++) mem[tile_addr(tile_row, k)] <= tile_word(17'({tile_row, 3'(k)}));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_noise();
    tile_ce = 1'($urandom);
    tile_we = 1'($urandom);
    if (tile_we) tile_row = 14'(100 + $urandom_range(0, 3));
    else         tile_row = 14'($urandom_range(0, 3));
  endtask

  task automatic tile_off();
    tile_ce = 1'b0;
    tile_we = 1'b0;
    tile_row = '0;
  endtask

  task automatic set_req(input logic we, input logic [16:0] addr, input logic [63:0] wd, input logic [7:0] be);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = we;
    cpu_if.req_addr  = addr;
    cpu_if.req_wdata = wd;
    cpu_if.req_be    = be;
  endtask

  task automatic run_txn(input logic we, input logic [16:0] addr, input logic [63:0] wd,
                         input logic [7:0] be, input bit noise,
                         output logic [63:0] rdata, output int lat, output int waits, output bit ok);
    ok = 1'b1; lat = 0; waits = 0; rdata = '0;
    set_req(we, addr, wd, be);
    cpu_if.rsp_ready = 1'b1;
    if (noise) drive_noise();
    @(negedge clk);
    while (!cpu_if.req_ready && waits < 20) begin
      @(posedge clk); #1;
      if (noise) drive_noise();
      @(negedge clk);
      waits++;
    end
    if (!cpu_if.req_ready) begin
      ok = 1'b0;
      @(posedge clk); #1;
      cpu_if.req_valid = 1'b0;
      tile_off();
      return;
    end
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    if (noise) drive_noise();
    lat = 1;
    @(negedge clk);
    while (!cpu_if.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      if (noise) drive_noise();
      @(negedge clk);
      lat++;
    end
    if (!cpu_if.rsp_valid) ok = 1'b0;
    else rdata = cpu_if.rsp_rdata;
    @(posedge clk); #1;
    tile_off();
  endtask

  task automatic test_reset();
    set_req(1'b0, 17'd5, '0, 8'hFF);
    cpu_if.rsp_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (b_ce !== 1'b0) begin errors++; $display("FAIL reset_bce_during: got %b expected 0", b_ce); end
    checks++;
    if (cpu_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rspv_during: got %b expected 0", cpu_if.rsp_valid); end
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rspv: got %b expected 0", cpu_if.rsp_valid); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
    checks++;
    if (cpu_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cpu_if.req_ready); end
    checks++;
    if (cpu_if.rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", cpu_if.rsp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_known();
    logic [63:0] rd; int lat, waits, rc0; bit ok;
    rc0 = rd_count;
    run_txn(1'b0, 17'd9, '0, 8'hFF, 1'b0, rd, lat, waits, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_known_timeout: got no response expected response"); end
    checks++;
    if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL read_known_data: got %h expected 1122334455667788", rd); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL read_known_lat: got %0d expected 2", lat); end
    checks++;
    if (rd_count - rc0 !== 1) begin errors++; $display("FAIL read_known_reads: got %0d expected 1", rd_count - rc0); end
  endtask

  task automatic test_partial_write();
    logic [63:0] rd; int lat, waits, wc0; bit ok;
    wc0 = wr_count;
    run_txn(1'b1, 17'd9, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0, rd, lat, waits, ok);
    ref_mem[9] = mrg(ref_rd(17'd9), 64'hAAAAAAAABBBBBBBB, 8'h0F);
    checks++;
    if (!ok) begin errors++; $display("FAIL pw_timeout: got no response expected response"); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL pw_lat: got %0d expected 3", lat); end
    checks++;
    if (wr_count - wc0 !== 1) begin errors++; $display("FAIL pw_writes: got %0d expected 1", wr_count - wc0); end
    checks++;
    if (last_wdata !== 64'h11223344BBBBBBBB) begin errors++; $display("FAIL pw_wdata: got %h expected 11223344bbbbbbbb", last_wdata); end
    checks++;
    if (last_waddr !== 17'd9) begin errors++; $display("FAIL pw_waddr: got %h expected 9", last_waddr); end
    checks++;
    if (rd !== 64'd0) begin errors++; $display("FAIL pw_rdata: got %h expected 0", rd); end
  endtask

  task automatic test_random();
    logic [63:0] rd, exp_d, wd; logic [16:0] a; logic [7:0] be; logic we;
    int lat, waits, sel; bit ok; logic [15:0] s0;
    s0 = stall_cnt;
    for (int n = 0; n < 40; n++) begin
      a  = 17'($urandom_range(0, 31));
      we = 1'($urandom);
      wd = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      be = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
      exp_d = we ? 64'd0 : ref_rd(a);
      run_txn(we, a, wd, be, 1'b1, rd, lat, waits, ok);
      if (we && be != 8'h00) ref_mem[int'(a)] = mrg(ref_rd(a), wd, be);
      checks++;
      if (!ok || waits != 0) begin errors++; $display("FAIL rand_accept[%0d]: got ok=%0b waits=%0d expected ok=1 waits=0", n, ok, waits); end
      checks++;
      if (lat !== exp_lat(we, be)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", n, lat, exp_lat(we, be)); end
      checks++;
      if (rd !== exp_d) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, rd, exp_d); end
    end
    checks++;
    if (stall_cnt !== s0) begin errors++; $display("FAIL rand_no_stall: got %0d expected %0d", stall_cnt, s0); end
    for (int k = 0; k < 32; k++) begin
      run_txn(1'b0, 17'(k), '0, 8'h00, 1'b0, rd, lat, waits, ok);
      checks++;
      if (rd !== ref_rd(17'(k))) begin errors++; $display("FAIL readback[%0d]: got %h expected %h", k, rd, ref_rd(17'(k))); end
    end
  endtask

  task automatic test_collision_stall();
    int lat; logic [63:0] rd;
    do_reset();
    set_req(1'b0, 17'd42, '0, 8'hFF);
    cpu_if.rsp_ready = 1'b1;
    tile_ce = 1'b1; tile_we = 1'b1; tile_row = 14'd5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (cpu_if.req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", c, cpu_if.req_ready); end
      @(posedge clk); #1;
    end
    tile_off();
    for (int k = 0; k < 8; k++) ref_mem[40 + k] = tile_word(17'(40 + k));
    @(negedge clk);
    checks++;
    if (cpu_if.req_ready !== 1'b1) begin errors++; $display("FAIL stall_accept: got %b expected 1", cpu_if.req_ready); end
    checks++;
    if (stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt4: got %0d expected 4", stall_cnt); end
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!cpu_if.rsp_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
    rd = cpu_if.rsp_rdata;
    checks++;
    if (rd !== ref_rd(17'd42)) begin errors++; $display("FAIL stall_data: got %h expected %h", rd, ref_rd(17'd42)); end
    @(posedge clk); #1;
  endtask

  task automatic test_rmw_collision();
    logic [63:0] wd, rd, exp_w; int lat, waits, wc0; bit ok;
    do_reset();
    wd = {$urandom, $urandom};
    wc0 = wr_count;
    set_req(1'b1, 17'd49, wd, 8'h3C);
    cpu_if.rsp_ready = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!cpu_if.req_ready && waits < 20) begin @(posedge clk); @(negedge clk); waits++; end
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    tile_ce = 1'b1; tile_we = 1'b1; tile_row = 14'd6;
    @(posedge clk); #1;
    tile_off();
    for (int k = 0; k < 8; k++) ref_mem[48 + k] = tile_word(17'(48 + k));
    exp_w = mrg(ref_rd(17'd49), wd, 8'h3C);
    ref_mem[49] = exp_w;
    lat = 0;
    @(negedge clk);
    while (!cpu_if.rsp_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
    checks++;
    if (cpu_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL rmwc_timeout: got no response expected response"); end
    @(posedge clk); #1;
    checks++;
    if (wr_count - wc0 !== 1) begin errors++; $display("FAIL rmwc_writes: got %0d expected 1", wr_count - wc0); end
    checks++;
    if (last_wdata !== exp_w) begin errors++; $display("FAIL rmwc_wdata: got %h expected %h", last_wdata, exp_w); end
    checks++;
    if (stall_cnt !== 16'd1) begin errors++; $display("FAIL rmwc_stall: got %0d expected 1", stall_cnt); end
    run_txn(1'b0, 17'd49, '0, 8'h00, 1'b0, rd, lat, waits, ok);
    checks++;
    if (rd !== exp_w) begin errors++; $display("FAIL rmwc_readback: got %h expected %h", rd, exp_w); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd0; int n;
    set_req(1'b0, 17'd3, '0, 8'hFF);
    cpu_if.rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cpu_if.req_ready && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cpu_if.rsp_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    rd0 = cpu_if.rsp_rdata;
    checks++;
    if (rd0 !== ref_rd(17'd3)) begin errors++; $display("FAIL bp_data: got %h expected %h", rd0, ref_rd(17'd3)); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (cpu_if.rsp_valid !== 1'b1 || cpu_if.rsp_rdata !== rd0 || cpu_if.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=0", c, cpu_if.rsp_valid, cpu_if.rsp_rdata, cpu_if.req_ready, rd0);
      end
      @(posedge clk); #1;
      if (c == 2) cpu_if.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cpu_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", cpu_if.rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; int lat, waits, wc0, n, seen; bit ok;
    wc0 = wr_count;
    set_req(1'b1, 17'd20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
    cpu_if.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cpu_if.req_ready && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (b_we !== 1'b0 || b_ce !== 1'b0) begin errors++; $display("FAIL rstmid_strobe: got ce=%b we=%b expected 0 0", b_ce, b_we); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cpu_if.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_rsp: got %0d valid cycles expected 0", seen); end
    checks++;
    if (wr_count - wc0 !== 0) begin errors++; $display("FAIL rstmid_writes: got %0d expected 0", wr_count - wc0); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stall: got %0d expected 0", stall_cnt); end
    checks++;
    if (cpu_if.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", cpu_if.req_ready); end
    @(posedge clk); #1;
    run_txn(1'b0, 17'd20, '0, 8'h00, 1'b0, rd, lat, waits, ok);
    checks++;
    if (rd !== ref_rd(17'd20)) begin errors++; $display("FAIL rstmid_mem: got %h expected %h", rd, ref_rd(17'd20)); end
  endtask

  initial begin
    cpu_if.req_valid = 1'b0;
    cpu_if.req_we    = 1'b0;
    cpu_if.req_addr  = '0;
    cpu_if.req_wdata = '0;
    cpu_if.req_be    = '0;
    cpu_if.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_read_known();
    test_partial_write();
    test_random();
    test_collision_stall();
    test_rmw_collision();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
